apb_tx_fifo_slave: RTL and testbench
====================================

Name: apb_tx_fifo_slave

Overview:
- Parametrised successor of the transmit-side APB register block.
- Holds prescale, command, ID and data-field registers.
- Replaces the single transmit register with a FIFO of depth FIFO_DEPTH, drained by the frame engine over a valid/ready interface.
- Adds PSLVERR, FIFO level/flags, flush, and a maskable W1C interrupt block.

Parameters:
- ADDRESSWIDTH, 4: APB word-address width; map uses addresses 0-9.
- DATAWIDTH, 16: APB data width; must be at least 16.
- FRAME_WIDTH, 12: width of one transmit FIFO entry; must not exceed DATAWIDTH.
- FIFO_DEPTH, 8: FIFO entries; power of 2, at least 2.

Ports:
- PCLK_tx  in  1  clock. One clock domain only.
- PRESETn_tx  in  1  reset, asynchronous, active-low.
- PADDR_tx_i  in  ADDRESSWIDTH  word address.
- PWDATA_tx_i  in  DATAWIDTH  write data.
- PWRITE_tx_i  in  1  1 = write.
- PSELx_tx_i  in  1  slave select.
- PENABLE_tx_i  in  1  access phase.
- PRDATA_tx_o  out  DATAWIDTH  read data.
- PREADY_tx_o  out  1  tied 1; zero wait states.
- PSLVERR_tx_o  out  1  error response.
- prescale_tx  out  8  prescale register.
- reg_command_tx  out  8  command register.
- reg_id_tx  out  8  frame ID register.
- reg_data_field_tx  out  16  data-field register.
- reg_status_tx  in  8  engine status; bit7 = busy.
- tx_done_i  in  1  engine frame-complete pulse or level.
- tx_data_o  out  FRAME_WIDTH  FIFO head.
- tx_valid_o  out  1  FIFO not empty.
- tx_ready_i  in  1  engine pops the head when high and tx_valid_o is high.
- irq_o  out  1  OR of (IRQ_STATUS & IRQ_ENABLE).

Behaviour:
- Transfer definition: a transfer completes on any edge where PSELx_tx_i & PENABLE_tx_i are high. All register side effects happen on that edge only, exactly once per transfer.
- PRDATA_tx_o is combinational:
  - read mux value during the access phase of a read;
  - 0 otherwise, and 0 for TXDATA and unmapped addresses.
- PSLVERR_tx_o is combinational, valid in the access phase. It asserts for:
  - any access to an unmapped address;
  - a write to a read-only register (5, 6);
  - a write to TXDATA while the FIFO is full.
- An errored write changes no register.

Address map:
- 0 PRESCALE, RW [7:0].
- 1 COMMAND, RW [6:0]. Bit7 = FLUSH, self-clearing, reads 0.
- 2 TXDATA, WO. Pushes PWDATA[FRAME_WIDTH-1:0] if not full. If full, the entry is dropped and IRQ bit0 is set.
- 3 ID, RW [7:0].
- 4 DATAFIELD, RW [15:0].
- 5 STATUS, RO:
  - [7:0] = reg_status_tx;
  - [8] = fifo empty;
  - [9] = fifo full.
- 6 LEVEL, RO: entry count, 0..FIFO_DEPTH.
- 7 IRQ_STATUS, W1C:
  - bit0 = overflow;
  - bit1 = FIFO drained (level went from 1 to 0 by a pop);
  - bit2 = rising edge of tx_done_i.
- 8 IRQ_ENABLE, RW [3:0].
- 9: see Optional Feature.

FIFO:
- Registered first-word-fall-through. tx_data_o = head entry, valid the same cycle tx_valid_o is high.
- Write latency: data pushed on edge N is visible on tx_data_o after edge N when the FIFO was empty.
- Pointers wrap modulo FIFO_DEPTH. Level is kept in a separate counter ($clog2(FIFO_DEPTH)+1 bits).
- Simultaneous push and pop, not full: level unchanged, both happen.
- Push when full with a concurrent pop: rejected. Full is evaluated before the pop.
- Pop when empty: impossible, since tx_valid_o is 0.
- FLUSH:
  - clears pointers and level on that edge;
  - overrides any concurrent push or pop;
  - does not set IRQ bit1.

IRQ:
- Set events win over a same-cycle W1C clear of the same bit.
- tx_done_i edge detect uses a 1-flop history register, reset to 0.

Reset (async, all outputs and state):
- All registers, FIFO pointers, level, IRQ status/enable and edge history = 0.
- Outputs: tx_valid_o = 0, tx_data_o = 0, irq_o = 0, PRDATA_tx_o = 0, PSLVERR_tx_o = 0.
- Reset mid-transfer aborts it with no side effect.

Optional Feature:
- Macro: TX_FIFO_WATERMARK_EN.
- Defined:
  - address 9 WATERMARK, RW [$clog2(FIFO_DEPTH):0], reset 0;
  - IRQ bit3 sets on the edge where level transitions from above WATERMARK to at or below WATERMARK by a pop;
  - IRQ_ENABLE bit3 becomes writable.
- Not defined:
  - address 9 is unmapped (PSLVERR);
  - IRQ_STATUS bit3 and IRQ_ENABLE bit3 read 0 and cannot be written.

Test Plan:
- Reset, then read addresses 0-8 → all read 0 except STATUS[8] = 1. PSLVERR = 0 on each; read of address 10 → PSLVERR = 1, PRDATA = 0.
- Push 0x0A1, 0x0B2, 0x0C3 with tx_ready_i = 0 → LEVEL = 3, tx_data_o = 0x0A1. Raise tx_ready_i for 3 cycles → outputs 0x0A1, 0x0B2, 0x0C3 in order; IRQ_STATUS bit1 = 1.
- Push 9 entries (FIFO_DEPTH = 8) → 9th write gives PSLVERR = 1 and IRQ bit0 = 1. With IRQ_ENABLE = 0x1, irq_o = 1; writing IRQ_STATUS = 0x1 clears it and irq_o drops.
- FIFO holds 1 entry; TXDATA write and tx_ready_i pop on the same edge → LEVEL stays 1, new entry at head. Same setup plus COMMAND = 0x80 → LEVEL = 0, COMMAND reads 0.
- Pulse tx_done_i high for 3 cycles → IRQ bit2 set once. A W1C of bit2 on the rising-edge cycle leaves bit2 set.
- With TX_FIFO_WATERMARK_EN, WATERMARK = 2, fill to 4, pop 2 → IRQ bit3 set on the edge where level becomes 2. Without the macro → address 9 access gives PSLVERR = 1.

Source files
------------

// File: rtl/apb_tx_fifo_slave.sv
// apb_tx_fifo_slave: APB register block for the CAN transmit path.
// Holds the prescale, command, ID and data-field registers, a transmit FIFO
// drained over valid/ready, FIFO level/flags, flush, and a maskable W1C
// interrupt block.
// Optional feature macro: TX_FIFO_WATERMARK_EN adds the WATERMARK register
// at address 9 and the watermark interrupt (IRQ bit3).
module apb_tx_fifo_slave #(
    parameter int unsigned ADDRESSWIDTH = 4,
    parameter int unsigned DATAWIDTH    = 16,
    parameter int unsigned FRAME_WIDTH  = 12,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                    PCLK_tx,
    input  logic                    PRESETn_tx,
    input  logic [ADDRESSWIDTH-1:0] PADDR_tx_i,
    input  logic [DATAWIDTH-1:0]    PWDATA_tx_i,
    input  logic                    PWRITE_tx_i,
    input  logic                    PSELx_tx_i,
    input  logic                    PENABLE_tx_i,
    output logic [DATAWIDTH-1:0]    PRDATA_tx_o,
    output logic                    PREADY_tx_o,
    output logic                    PSLVERR_tx_o,
    output logic [7:0]              prescale_tx,
    output logic [7:0]              reg_command_tx,
    output logic [7:0]              reg_id_tx,
    output logic [15:0]             reg_data_field_tx,
    input  logic [7:0]              reg_status_tx,
    input  logic                    tx_done_i,
    output logic [FRAME_WIDTH-1:0]  tx_data_o,
    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    irq_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned IRQ_W = 4;

    localparam logic [ADDRESSWIDTH-1:0] ADDR_PRESCALE = ADDRESSWIDTH'(0);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_COMMAND  = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_TXDATA   = ADDRESSWIDTH'(2);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_ID       = ADDRESSWIDTH'(3);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_DFIELD   = ADDRESSWIDTH'(4);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_STATUS   = ADDRESSWIDTH'(5);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_LEVEL    = ADDRESSWIDTH'(6);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_IRQST    = ADDRESSWIDTH'(7);
    localparam logic [ADDRESSWIDTH-1:0] ADDR_IRQEN    = ADDRESSWIDTH'(8);
`ifdef TX_FIFO_WATERMARK_EN
    localparam logic [ADDRESSWIDTH-1:0] ADDR_WMARK    = ADDRESSWIDTH'(9);
    localparam logic [IRQ_W-1:0]        IRQ_MASK      = 4'hF;
`else
    localparam logic [IRQ_W-1:0]        IRQ_MASK      = 4'h7;
`endif

    logic [7:0]             prescale_q, prescale_d;
    logic [6:0]             cmd_q, cmd_d;
    logic [7:0]             id_q, id_d;
    logic [15:0]            df_q, df_d;
    logic [IRQ_W-1:0]       irq_st_q, irq_st_d;
    logic [IRQ_W-1:0]       irq_en_q, irq_en_d;
    logic                   done_q;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [FRAME_WIDTH-1:0] mem_q [FIFO_DEPTH];
`ifdef TX_FIFO_WATERMARK_EN
    logic [LVL_W-1:0]       wm_q, wm_d;
`endif

    logic                   xfer, wr_xfer, rd_xfer, mapped, err;
    logic                   full, empty, wr_ok, flush, push, pop;
    logic [IRQ_W-1:0]       irq_set, irq_clr;
    logic [DATAWIDTH-1:0]   rdata;

    // Transfer qualification, FIFO flags and error decode
    always_comb begin
        xfer    = PSELx_tx_i & PENABLE_tx_i;
        wr_xfer = xfer & PWRITE_tx_i;
        rd_xfer = xfer & ~PWRITE_tx_i;
        full    = (level_q == LVL_W'(FIFO_DEPTH));
        empty   = (level_q == '0);
`ifdef TX_FIFO_WATERMARK_EN
        mapped  = (PADDR_tx_i <= ADDR_WMARK);
`else
        mapped  = (PADDR_tx_i <= ADDR_IRQEN);
`endif
        err     = xfer & (~mapped
                  | (PWRITE_tx_i & ((PADDR_tx_i == ADDR_STATUS) | (PADDR_tx_i == ADDR_LEVEL)))
                  | (PWRITE_tx_i & (PADDR_tx_i == ADDR_TXDATA) & full));
        wr_ok   = wr_xfer & ~err;
        flush   = wr_ok & (PADDR_tx_i == ADDR_COMMAND) & PWDATA_tx_i[7];
        push    = wr_ok & (PADDR_tx_i == ADDR_TXDATA);
        // Flush overrides a concurrent pop
        pop     = ~empty & tx_ready_i & ~flush;
    end

    // Next-state for registers, FIFO pointers/level and interrupt status
    always_comb begin
        prescale_d = prescale_q;
        cmd_d      = cmd_q;
        id_d       = id_q;
        df_d       = df_q;
        irq_en_d   = irq_en_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        irq_set    = '0;
        irq_clr    = '0;
`ifdef TX_FIFO_WATERMARK_EN
        wm_d       = wm_q;
`endif
        if (wr_ok) begin
            case (PADDR_tx_i)
                ADDR_PRESCALE: prescale_d = PWDATA_tx_i[7:0];
                ADDR_COMMAND:  cmd_d      = PWDATA_tx_i[6:0];
                ADDR_ID:       id_d       = PWDATA_tx_i[7:0];
                ADDR_DFIELD:   df_d       = PWDATA_tx_i[15:0];
                ADDR_IRQST:    irq_clr    = PWDATA_tx_i[IRQ_W-1:0];
                ADDR_IRQEN:    irq_en_d   = PWDATA_tx_i[IRQ_W-1:0] & IRQ_MASK;
`ifdef TX_FIFO_WATERMARK_EN
                ADDR_WMARK:    wm_d       = PWDATA_tx_i[LVL_W-1:0];
`endif
                default: ;
            endcase
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      level_d = level_q + LVL_W'(1);
            else if (pop && !push) level_d = level_q - LVL_W'(1);
        end

        irq_set[0] = wr_xfer & (PADDR_tx_i == ADDR_TXDATA) & full;
        irq_set[1] = pop & ~push & (level_q == LVL_W'(1));
        irq_set[2] = tx_done_i & ~done_q;
`ifdef TX_FIFO_WATERMARK_EN
        irq_set[3] = pop & ~push & (level_q > wm_q) & ((level_q - LVL_W'(1)) <= wm_q);
`endif
        // Set events win over a same-cycle clear
        irq_st_d = ((irq_st_q & ~irq_clr) | irq_set) & IRQ_MASK;
    end

    // State registers
    always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
        if (!PRESETn_tx) begin
            prescale_q <= '0;
            cmd_q      <= '0;
            id_q       <= '0;
            df_q       <= '0;
            irq_st_q   <= '0;
            irq_en_q   <= '0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
`ifdef TX_FIFO_WATERMARK_EN
            wm_q       <= '0;
`endif
        end else begin
            prescale_q <= prescale_d;
            cmd_q      <= cmd_d;
            id_q       <= id_d;
            df_q       <= df_d;
            irq_st_q   <= irq_st_d;
            irq_en_q   <= irq_en_d;
            done_q     <= tx_done_i;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
`ifdef TX_FIFO_WATERMARK_EN
            wm_q       <= wm_d;
`endif
        end
    end

    // FIFO storage
    always_ff @(posedge PCLK_tx or negedge PRESETn_tx) begin
        if (!PRESETn_tx) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= PWDATA_tx_i[FRAME_WIDTH-1:0];
        end
    end

    // Read mux; TXDATA and unmapped addresses read 0
    always_comb begin
        rdata = '0;
        case (PADDR_tx_i)
            ADDR_PRESCALE: rdata = DATAWIDTH'(prescale_q);
            ADDR_COMMAND:  rdata = DATAWIDTH'(cmd_q);
            ADDR_ID:       rdata = DATAWIDTH'(id_q);
            ADDR_DFIELD:   rdata = DATAWIDTH'(df_q);
            ADDR_STATUS:   rdata = DATAWIDTH'({full, empty, reg_status_tx});
            ADDR_LEVEL:    rdata = DATAWIDTH'(level_q);
            ADDR_IRQST:    rdata = DATAWIDTH'(irq_st_q);
            ADDR_IRQEN:    rdata = DATAWIDTH'(irq_en_q);
`ifdef TX_FIFO_WATERMARK_EN
            ADDR_WMARK:    rdata = DATAWIDTH'(wm_q);
`endif
            default:       rdata = '0;
        endcase
    end

    assign PRDATA_tx_o       = (rd_xfer & PRESETn_tx) ? rdata : '0;
    assign PSLVERR_tx_o      = err & PRESETn_tx;
    assign PREADY_tx_o       = 1'b1;
    assign prescale_tx       = prescale_q;
    assign reg_command_tx    = {1'b0, cmd_q};
    assign reg_id_tx         = id_q;
    assign reg_data_field_tx = df_q;
    assign tx_valid_o        = ~empty;
    assign tx_data_o         = empty ? '0 : mem_q[rd_ptr_q];
    assign irq_o             = |(irq_st_q & irq_en_q);

endmodule

// File: tb/tb_apb_tx_fifo_slave.sv
// Scoreboard bench for apb_tx_fifo_slave: a queue-based reference model
// predicts APB responses and FIFO output; a monitor compares on handshakes.
module tb_apb_tx_fifo_slave;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned FW = 12;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic          pwrite = 1'b0, psel = 1'b0, pen = 1'b0;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;
    logic [7:0]    pre_o, cmd_o, id_o;
    logic [15:0]   df_o;
    logic [7:0]    st_in = '0;
    logic          tx_done = 1'b0, tx_ready = 1'b0;
    logic [FW-1:0] tx_data;
    logic          tx_valid, irq;

    apb_tx_fifo_slave #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .FRAME_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
        .PCLK_tx(clk), .PRESETn_tx(rst_n), .PADDR_tx_i(paddr), .PWDATA_tx_i(pwdata),
        .PWRITE_tx_i(pwrite), .PSELx_tx_i(psel), .PENABLE_tx_i(pen), .PRDATA_tx_o(prdata),
        .PREADY_tx_o(pready), .PSLVERR_tx_o(pslverr), .prescale_tx(pre_o),
        .reg_command_tx(cmd_o), .reg_id_tx(id_o), .reg_data_field_tx(df_o),
        .reg_status_tx(st_in), .tx_done_i(tx_done), .tx_data_o(tx_data),
        .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic        irq;
        logic [7:0]  pre, cmd, id;
        logic [15:0] df;
    } apb_exp_t;

    apb_exp_t      apb_q[$];
    logic [FW-1:0] tx_q[$];
    logic [FW-1:0] fifo_m[$];
    logic [7:0]    m_pre, m_id;
    logic [6:0]    m_cmd;
    logic [15:0]   m_df;
    logic [3:0]    m_ist, m_ien, m_wm;
    logic          m_done_h;
    int            vectors = 0;
    int            errors = 0;
    logic          rdy_v = 1'b0, done_v = 1'b0, rand_mode = 1'b0;
    logic [7:0]    st_v = '0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre = '0; m_id = '0; m_cmd = '0; m_df = '0;
        m_ist = '0; m_ien = '0; m_wm = '0; m_done_h = 1'b0;
        fifo_m.delete();
    endtask

    function automatic logic [15:0] rd_val(input logic [3:0] a, input int sz);
        case (a)
            4'd0: return 16'(m_pre);
            4'd1: return 16'(m_cmd);
            4'd3: return 16'(m_id);
            4'd4: return m_df;
            4'd5: return {6'b0, sz == DEPTH, sz == 0, st_in};
            4'd6: return 16'(sz);
            4'd7: return 16'(m_ist);
            4'd8: return 16'(m_ien);
`ifdef TX_FIFO_WATERMARK_EN
            4'd9: return 16'(m_wm);
`endif
            default: return 16'h0;
        endcase
    endfunction

    // Predict this cycle's response from the pre-edge model, then advance it
    task automatic model_edge();
        logic xfer, wr, full, err, mapped, push, pop, flush;
        logic [3:0] a, set, clr;
        logic [15:0] d;
        int sz;
        apb_exp_t e;
        a = paddr; d = pwdata; wr = pwrite; xfer = psel && pen;
        sz = fifo_m.size(); full = (sz == DEPTH);
`ifdef TX_FIFO_WATERMARK_EN
        mapped = (a <= 4'd9);
`else
        mapped = (a <= 4'd8);
`endif
        err = xfer && (!mapped || (wr && (a == 4'd5 || a == 4'd6)) || (wr && a == 4'd2 && full));
        if (xfer) begin
            e.rdata = wr ? 16'h0 : rd_val(a, sz);
            e.err = err; e.irq = |(m_ist & m_ien);
            e.pre = m_pre; e.cmd = {1'b0, m_cmd}; e.id = m_id; e.df = m_df;
            apb_q.push_back(e);
        end
        pop = (sz > 0) && tx_ready;
        if (pop) tx_q.push_back(fifo_m[0]);
        push  = xfer && wr && !err && a == 4'd2;
        flush = xfer && wr && !err && a == 4'd1 && d[7];
        set = '0;
        set[0] = xfer && wr && a == 4'd2 && full;
        set[1] = pop && !push && !flush && sz == 1;
        set[2] = tx_done && !m_done_h;
`ifdef TX_FIFO_WATERMARK_EN
        set[3] = pop && !push && !flush && sz > int'(m_wm) && sz - 1 <= int'(m_wm);
`endif
        clr = '0;
        if (xfer && wr && !err) begin
            case (a)
                4'd0: m_pre = d[7:0];
                4'd1: m_cmd = d[6:0];
                4'd3: m_id = d[7:0];
                4'd4: m_df = d;
                4'd7: clr = d[3:0];
`ifdef TX_FIFO_WATERMARK_EN
                4'd8: m_ien = d[3:0];
                4'd9: m_wm = d[3:0];
`else
                4'd8: m_ien = d[3:0] & 4'h7;
`endif
                default: ;
            endcase
        end
        m_ist = (m_ist & ~clr) | set;
        if (flush) fifo_m.delete();
        else begin
            if (pop) void'(fifo_m.pop_front());
            if (push) fifo_m.push_back(d[FW-1:0]);
        end
        m_done_h = tx_done;
    endtask

    // One clock cycle of stimulus; inputs change just after the rising edge
    task automatic step(input logic sel, input logic en, input logic wr,
                        input logic [3:0] a, input logic [15:0] d);
        if (rand_mode) begin
            rdy_v = 1'($urandom_range(0, 1));
            done_v = ($urandom_range(0, 3) == 0);
            st_v = 8'($urandom);
        end
        psel = sel; pen = en; pwrite = wr; paddr = a; pwdata = d;
        tx_ready = rdy_v; tx_done = done_v; st_in = st_v;
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic apb(input logic wr, input logic [3:0] a, input logic [15:0] d);
        step(1'b1, 1'b0, wr, a, d);
        step(1'b1, 1'b1, wr, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    endtask

    // Monitor: compares APB responses in the access phase and FIFO output on handshake
    always @(negedge clk) begin
        apb_exp_t e;
        if (rst_n) begin
            if (psel && pen) begin
                if (apb_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL apb_unexpected: access with no prediction at %0t", $time);
                end else begin
                    e = apb_q.pop_front();
                    chk("prdata", prdata, e.rdata);
                    chk("pslverr", 16'(pslverr), 16'(e.err));
                    chk("pready", 16'(pready), 16'h1);
                    chk("irq_o", 16'(irq), 16'(e.irq));
                    chk("prescale_tx", 16'(pre_o), 16'(e.pre));
                    chk("reg_command_tx", 16'(cmd_o), 16'(e.cmd));
                    chk("reg_id_tx", 16'(id_o), 16'(e.id));
                    chk("reg_data_field_tx", df_o, e.df);
                end
            end else begin
                chk("prdata_idle", prdata, 16'h0);
                chk("pslverr_idle", 16'(pslverr), 16'h0);
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    vectors++; errors++;
                    $display("FAIL tx_unexpected: pop of %h with empty model at %0t", tx_data, $time);
                end else chk("tx_data", 16'(tx_data), 16'(tx_q.pop_front()));
            end else if (!tx_valid) begin
                chk("tx_data_empty", 16'(tx_data), 16'h0);
            end
        end
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_valid", 16'(tx_valid), 16'h0);
        chk("reset_irq", 16'(irq), 16'h0);
        chk("reset_prdata", prdata, 16'h0);
        rst_n = 1'b1;

        // Reset values of the whole map, plus an unmapped address
        for (int a = 0; a <= 10; a++) apb(1'b0, 4'(a), 16'h0);

        // Three pushes held back, then drained in order
        rdy_v = 1'b0;
        apb(1'b1, 4'd2, 16'h00A1);
        apb(1'b1, 4'd2, 16'h00B2);
        apb(1'b1, 4'd2, 16'h00C3);
        apb(1'b0, 4'd6, 16'h0);
        rdy_v = 1'b1; idle(3); rdy_v = 1'b0;
        apb(1'b0, 4'd7, 16'h0);
        apb(1'b1, 4'd7, 16'h000F);

        // Overflow, interrupt enable and W1C clear
        apb(1'b1, 4'd8, 16'h0001);
        for (int i = 0; i < 9; i++) apb(1'b1, 4'd2, 16'(16'h100 + i));
        apb(1'b0, 4'd6, 16'h0);
        apb(1'b0, 4'd7, 16'h0);
        apb(1'b1, 4'd7, 16'h0001);
        apb(1'b0, 4'd7, 16'h0);
        apb(1'b1, 4'd1, 16'h0080);
        apb(1'b0, 4'd6, 16'h0);

        // Concurrent push/pop with one entry, then pop against flush
        apb(1'b1, 4'd2, 16'h0111);
        step(1'b1, 1'b0, 1'b1, 4'd2, 16'h0222);
        rdy_v = 1'b1; step(1'b1, 1'b1, 1'b1, 4'd2, 16'h0222); rdy_v = 1'b0;
        apb(1'b0, 4'd6, 16'h0);
        step(1'b1, 1'b0, 1'b1, 4'd1, 16'h0080);
        rdy_v = 1'b1; step(1'b1, 1'b1, 1'b1, 4'd1, 16'h0080); rdy_v = 1'b0;
        apb(1'b0, 4'd6, 16'h0);
        apb(1'b0, 4'd1, 16'h0);
        apb(1'b0, 4'd7, 16'h0);

        // tx_done held for 3 cycles sets bit2 once; W1C on the rising edge loses
        apb(1'b1, 4'd7, 16'h000F);
        done_v = 1'b1; idle(3); done_v = 1'b0;
        apb(1'b0, 4'd7, 16'h0);
        apb(1'b1, 4'd7, 16'h0004);
        apb(1'b0, 4'd7, 16'h0);
        step(1'b1, 1'b0, 1'b1, 4'd7, 16'h0004);
        done_v = 1'b1; step(1'b1, 1'b1, 1'b1, 4'd7, 16'h0004); done_v = 1'b0;
        apb(1'b0, 4'd7, 16'h0);
        apb(1'b1, 4'd7, 16'h000F);

        // Watermark register, or unmapped address 9
        apb(1'b1, 4'd9, 16'h0002);
        apb(1'b0, 4'd9, 16'h0);
        for (int i = 0; i < 4; i++) apb(1'b1, 4'd2, 16'(16'h300 + i));
        rdy_v = 1'b1; idle(1);
        apb(1'b0, 4'd7, 16'h0);
        rdy_v = 1'b1; idle(1); rdy_v = 1'b0;
        apb(1'b0, 4'd7, 16'h0);
        apb(1'b0, 4'd6, 16'h0);
        apb(1'b1, 4'd8, 16'h000F);
        apb(1'b0, 4'd8, 16'h0);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            int r;
            logic [3:0] a;
            logic [15:0] d;
            logic wr;
            r = int'($urandom_range(0, 15));
            a = (r < 6) ? 4'd2 : 4'($urandom_range(0, 10));
            wr = (r < 5) ? 1'b1 : 1'($urandom_range(0, 1));
            d = 16'($urandom);
            if (a == 4'd1 && $urandom_range(0, 7) != 0) d[7] = 1'b0;
            if ($urandom_range(0, 3) == 0) idle(1);
            apb(wr, a, d);
        end
        rand_mode = 1'b0;
        rdy_v = 1'b1; idle(DEPTH + 2); rdy_v = 1'b0;
        idle(1);

        chk("apb_q_drained", 16'(apb_q.size()), 16'h0);
        chk("tx_q_drained", 16'(tx_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
